usb_hub_port_ctrl: RTL and testbench

Per-downstream-port connection and enable manager for the USB hub, parametrised over the number of downstream ports. It samples each port's synchronised D+/D- line state and debounces attach. It detects full/low speed and detect disconnects, and sequences hub-driven port reset (SE0) and enable/disable. It sits between the downstream pad logic in `usb_hub_top` and the hub class request handler, and reports sticky change bits for the hub status-change endpoint.

---
 rtl/usb_hub_port_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_usb_hub_port_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_hub_port_ctrl.sv
// usb_hub_port_ctrl: per-downstream-port attach debounce, speed detect, hub-driven reset and enable.
// Optional overcurrent handling is compiled in when USB_HUB_PORT_OVERCURRENT_EN is defined.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_DISC    | no device; waiting for the first J or K idle sample
// ST_DEB     | counting consecutive identical idle samples toward attach
// ST_DIS     | device attached, port disabled; watching for SE0 detach
// ST_RST     | hub drives SE0 for RESET_CYCLES; detach detection suppressed
// ST_EN      | device attached and enabled; watching for SE0 detach
module usb_hub_port_ctrl #(
    parameter int NUM_USB_DEVICES   = 4,
    parameter int DEBOUNCE_CYCLES   = 100,
    parameter int RESET_CYCLES      = 50,
    parameter int DISCONNECT_CYCLES = 20
) (
    input  logic                       hi_clock,
    input  logic                       reset,
    input  logic [NUM_USB_DEVICES-1:0] device_d_plus_in,
    input  logic [NUM_USB_DEVICES-1:0] device_d_minus_in,
    input  logic [NUM_USB_DEVICES-1:0] port_reset_req,
    input  logic [NUM_USB_DEVICES-1:0] port_disable_req,
    input  logic [NUM_USB_DEVICES-1:0] port_change_clear,
    output logic [NUM_USB_DEVICES-1:0] port_connected,
    output logic [NUM_USB_DEVICES-1:0] port_enabled,
    output logic [NUM_USB_DEVICES-1:0] port_low_speed,
    output logic [NUM_USB_DEVICES-1:0] port_drive_se0,
    output logic [NUM_USB_DEVICES-1:0] port_connect_change,
    output logic [NUM_USB_DEVICES-1:0] port_reset_change,
`ifdef USB_HUB_PORT_OVERCURRENT_EN
    input  logic [NUM_USB_DEVICES-1:0] port_overcurrent,
    output logic [NUM_USB_DEVICES-1:0] port_oc_change,
`endif
    output logic                       hub_status_change
);

    localparam int MAX_AB  = (DEBOUNCE_CYCLES > RESET_CYCLES) ? DEBOUNCE_CYCLES : RESET_CYCLES;
    localparam int MAX_CYC = (MAX_AB > DISCONNECT_CYCLES) ? MAX_AB : DISCONNECT_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] DEB_TC  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] RST_TC  = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] DISC_TC = CW'(DISCONNECT_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        ST_DISC = 3'd0,
        ST_DEB  = 3'd1,
        ST_DIS  = 3'd2,
        ST_RST  = 3'd3,
        ST_EN   = 3'd4
    } state_t;

    for (genvar i = 0; i < NUM_USB_DEVICES; i++) begin : g_port
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
        logic          pol_q, pol_d;
        logic          conn_q, conn_d;
        logic          en_q, en_d;
        logic          ls_q, ls_d;
        logic          se0_q, se0_d;
        logic          cchg_q, cchg_d;
        logic          rchg_q, rchg_d;
        logic          cchg_set, rchg_set;
        logic          ln_j, ln_k, ln_se0, ln_idle;
        logic          oc_hit, rst_go;

        assign ln_j    = device_d_plus_in[i] & ~device_d_minus_in[i];
        assign ln_k    = device_d_minus_in[i] & ~device_d_plus_in[i];
        assign ln_se0  = ~device_d_plus_in[i] & ~device_d_minus_in[i];
        assign ln_idle = ln_j | ln_k;
        assign cnt_inc = cnt_q + CNT_ONE;

`ifdef USB_HUB_PORT_OVERCURRENT_EN
        logic occhg_q, occhg_d;

        assign oc_hit = port_overcurrent[i] &
                        ((state_q == ST_DIS) || (state_q == ST_RST) || (state_q == ST_EN));
        assign rst_go = port_reset_req[i] & ~port_overcurrent[i];

        always_ff @(posedge hi_clock) begin
            if (reset) begin
                occhg_q <= 1'b0;
            end else begin
                occhg_q <= occhg_d;
            end
        end

        always_comb begin
            occhg_d = oc_hit | (occhg_q & ~port_change_clear[i]);
        end

        assign port_oc_change[i] = occhg_q;
`else
        assign oc_hit = 1'b0;
        assign rst_go = port_reset_req[i];
`endif

        // State register
        always_ff @(posedge hi_clock) begin
            if (reset) begin
                state_q <= ST_DISC;
                cnt_q   <= '0;
                pol_q   <= 1'b0;
                conn_q  <= 1'b0;
                en_q    <= 1'b0;
                ls_q    <= 1'b0;
                se0_q   <= 1'b0;
                cchg_q  <= 1'b0;
                rchg_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pol_q   <= pol_d;
                conn_q  <= conn_d;
                en_q    <= en_d;
                ls_q    <= ls_d;
                se0_q   <= se0_d;
                cchg_q  <= cchg_d;
                rchg_q  <= rchg_d;
            end
        end

        // Next-state logic; pol_q is 1 when the captured idle polarity is K
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            pol_d    = pol_q;
            conn_d   = conn_q;
            en_d     = en_q;
            ls_d     = ls_q;
            se0_d    = se0_q;
            cchg_set = 1'b0;
            rchg_set = 1'b0;

            if (oc_hit) begin
                state_d = ST_DIS;
                cnt_d   = '0;
                en_d    = 1'b0;
                se0_d   = 1'b0;
            end else begin
                case (state_q)
                    ST_DISC: begin
                        if (ln_idle) begin
                            pol_d   = ln_k;
                            cnt_d   = CNT_ONE;
                            state_d = ST_DEB;
                        end
                    end
                    ST_DEB: begin
                        if (ln_se0) begin
                            state_d = ST_DISC;
                            cnt_d   = '0;
                        end else if (ln_idle) begin
                            if (ln_k != pol_q) begin
                                pol_d = ln_k;
                                cnt_d = CNT_ONE;
                            end else if (cnt_inc == DEB_TC) begin
                                state_d  = ST_DIS;
                                cnt_d    = '0;
                                conn_d   = 1'b1;
                                ls_d     = pol_q;
                                cchg_set = 1'b1;
                            end else begin
                                cnt_d = cnt_inc;
                            end
                        end
                    end
                    ST_DIS, ST_EN: begin
                        if (ln_se0 && (cnt_inc == DISC_TC)) begin
                            state_d  = ST_DISC;
                            cnt_d    = '0;
                            conn_d   = 1'b0;
                            en_d     = 1'b0;
                            ls_d     = 1'b0;
                            cchg_set = 1'b1;
                        end else if (rst_go) begin
                            state_d = ST_RST;
                            cnt_d   = '0;
                            en_d    = 1'b0;
                            se0_d   = 1'b1;
                        end else begin
                            if (ln_se0) begin
                                cnt_d = cnt_inc;
                            end else if (ln_idle) begin
                                cnt_d = '0;
                            end
                            if ((state_q == ST_EN) && port_disable_req[i]) begin
                                state_d = ST_DIS;
                                en_d    = 1'b0;
                            end
                        end
                    end
                    ST_RST: begin
                        if (cnt_inc == RST_TC) begin
                            state_d  = ST_EN;
                            cnt_d    = '0;
                            en_d     = 1'b1;
                            se0_d    = 1'b0;
                            rchg_set = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    default: begin
                        state_d = ST_DISC;
                        cnt_d   = '0;
                        conn_d  = 1'b0;
                        en_d    = 1'b0;
                        se0_d   = 1'b0;
                    end
                endcase
            end

            // A set event in the same cycle as a clear keeps the bit set
            cchg_d = cchg_set | (cchg_q & ~port_change_clear[i]);
            rchg_d = rchg_set | (rchg_q & ~port_change_clear[i]);
        end

        // Output logic
        assign port_connected[i]      = conn_q;
        assign port_enabled[i]        = en_q;
        assign port_low_speed[i]      = ls_q;
        assign port_drive_se0[i]      = se0_q;
        assign port_connect_change[i] = cchg_q;
        assign port_reset_change[i]   = rchg_q;
    end

`ifdef USB_HUB_PORT_OVERCURRENT_EN
    assign hub_status_change = |{port_connect_change, port_reset_change, port_oc_change};
`else
    assign hub_status_change = |{port_connect_change, port_reset_change};
`endif

endmodule

// File: tb/tb_usb_hub_port_ctrl.sv
// Bench for usb_hub_port_ctrl: directed scenarios with literal expectations, then randomized
// line/request traffic, all compared every cycle against a run-length based port model.
module tb_usb_hub_port_ctrl;
    localparam int N    = 2;
    localparam int DEB  = 8;
    localparam int RST  = 10;
    localparam int DISC = 4;

    logic         hi_clock = 1'b0;
    logic         reset    = 1'b1;
    logic [N-1:0] dp = '0, dm = '0, rreq = '0, dreq = '0, clr = '0;
    logic [N-1:0] conn, en, ls, se0, cc, rc;
    logic         hub;
`ifdef USB_HUB_PORT_OVERCURRENT_EN
    logic [N-1:0] oc = '0;
    logic [N-1:0] occ;
`endif

    usb_hub_port_ctrl #(
        .NUM_USB_DEVICES  (N),
        .DEBOUNCE_CYCLES  (DEB),
        .RESET_CYCLES     (RST),
        .DISCONNECT_CYCLES(DISC)
    ) dut (
        .hi_clock           (hi_clock),
        .reset              (reset),
        .device_d_plus_in   (dp),
        .device_d_minus_in  (dm),
        .port_reset_req     (rreq),
        .port_disable_req   (dreq),
        .port_change_clear  (clr),
        .port_connected     (conn),
        .port_enabled       (en),
        .port_low_speed     (ls),
        .port_drive_se0     (se0),
        .port_connect_change(cc),
        .port_reset_change  (rc),
`ifdef USB_HUB_PORT_OVERCURRENT_EN
        .port_overcurrent   (oc),
        .port_oc_change     (occ),
`endif
        .hub_status_change  (hub)
    );

    always #5 hi_clock = ~hi_clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    // Model: connection is a run-length of identical idle samples, detach a run-length of SE0,
    // reset a remaining-cycle count.
    bit m_conn[N], m_en[N], m_ls[N], m_cc[N], m_rc[N];
    int m_run[N], m_runpol[N], m_se0run[N], m_rleft[N];

    task automatic chk(input string nm, input int p, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s port %0d: got %0h expected %0h at %0t", nm, p, act, exp, $time);
        end
    endtask

    task automatic model_step(input int p);
        bit s0, idle, kp, setc, setr;
        s0   = !dp[p] && !dm[p];
        idle = dp[p] != dm[p];
        kp   = dm[p];
        setc = 1'b0;
        setr = 1'b0;
        if (!m_conn[p]) begin
            if (s0) begin
                m_run[p] = 0;
            end else if (idle) begin
                if (m_run[p] > 0 && m_runpol[p] == int'(kp)) m_run[p]++;
                else begin
                    m_run[p]    = 1;
                    m_runpol[p] = int'(kp);
                end
                if (m_run[p] == DEB) begin
                    m_conn[p]   = 1'b1;
                    m_ls[p]     = (m_runpol[p] == 1);
                    setc        = 1'b1;
                    m_run[p]    = 0;
                    m_se0run[p] = 0;
                end
            end
        end else if (m_rleft[p] > 0) begin
            m_rleft[p]--;
            if (m_rleft[p] == 0) begin
                m_en[p] = 1'b1;
                setr    = 1'b1;
            end
        end else begin
            if (s0) m_se0run[p]++;
            else if (idle) m_se0run[p] = 0;
            if (m_se0run[p] == DISC) begin
                m_conn[p]   = 1'b0;
                m_en[p]     = 1'b0;
                setc        = 1'b1;
                m_se0run[p] = 0;
                m_run[p]    = 0;
            end else if (rreq[p]) begin
                m_rleft[p]  = RST;
                m_en[p]     = 1'b0;
                m_se0run[p] = 0;
            end else if (dreq[p]) begin
                m_en[p] = 1'b0;
            end
        end
        m_cc[p] = setc | (m_cc[p] & !clr[p]);
        m_rc[p] = setr | (m_rc[p] & !clr[p]);
    endtask

    always @(posedge hi_clock) begin
        for (int p = 0; p < N; p++) begin
            if (reset) begin
                m_conn[p] = 0; m_en[p] = 0; m_ls[p] = 0; m_cc[p] = 0; m_rc[p] = 0;
                m_run[p] = 0; m_runpol[p] = 0; m_se0run[p] = 0; m_rleft[p] = 0;
            end else begin
                model_step(p);
            end
        end
    end

    always @(negedge hi_clock) begin
        if (checking) begin
            bit any_chg;
            any_chg = 1'b0;
            for (int p = 0; p < N; p++) begin
                chk("connected", p, 8'(conn[p]), 8'(m_conn[p]));
                chk("enabled", p, 8'(en[p]), 8'(m_en[p]));
                chk("drive_se0", p, 8'(se0[p]), 8'(m_rleft[p] > 0));
                chk("connect_change", p, 8'(cc[p]), 8'(m_cc[p]));
                chk("reset_change", p, 8'(rc[p]), 8'(m_rc[p]));
                if (m_conn[p]) chk("low_speed", p, 8'(ls[p]), 8'(m_ls[p]));
                any_chg = any_chg | m_cc[p] | m_rc[p];
            end
            chk("hub_status_change", -1, 8'(hub), 8'(any_chg));
        end
    end

    task automatic step();
        @(negedge hi_clock);
    endtask

    // code: 0 = SE0, 1 = J, 2 = K, 3 = SE1
    task automatic line(input int p, input int code);
        dp[p] = (code == 1) || (code == 3);
        dm[p] = (code == 2) || (code == 3);
    endtask

    int hold[N];

    initial begin
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checking = 1'b1;
        chk("lit_reset_connected", -1, 8'(conn), 8'h0);
        chk("lit_reset_se0", -1, 8'(se0), 8'h0);
        chk("lit_reset_hub", -1, 8'(hub), 8'h0);

        // Attach full speed on port 0, low speed on port 1
        line(0, 1);
        repeat (7) step();
        chk("lit_attach_early", 0, 8'(conn[0]), 8'h0);
        step();
        chk("lit_attach_conn", 0, 8'(conn[0]), 8'h1);
        chk("lit_attach_ls", 0, 8'(ls[0]), 8'h0);
        chk("lit_attach_hub", -1, 8'(hub), 8'h1);
        line(1, 2);
        repeat (7) step();
        chk("lit_attach_k_early", 1, 8'(conn[1]), 8'h0);
        step();
        chk("lit_attach_k_conn", 1, 8'(conn[1]), 8'h1);
        chk("lit_attach_k_ls", 1, 8'(ls[1]), 8'h1);

        clr = 2'b11;
        step();
        clr = '0;
        chk("lit_clear_hub", -1, 8'(hub), 8'h0);
        chk("lit_clear_cc", -1, 8'(cc), 8'h0);

        // Port reset with a redundant request in the middle
        rreq[0] = 1'b1;
        step();
        rreq[0] = 1'b0;
        chk("lit_rst_se0_start", 0, 8'(se0[0]), 8'h1);
        chk("lit_rst_en_low", 0, 8'(en[0]), 8'h0);
        for (int i = 1; i <= 9; i++) begin
            if (i == 4) rreq[0] = 1'b1;
            step();
            rreq[0] = 1'b0;
            chk("lit_rst_se0_hold", 0, 8'(se0[0]), 8'h1);
        end
        step();
        chk("lit_rst_se0_end", 0, 8'(se0[0]), 8'h0);
        chk("lit_rst_enabled", 0, 8'(en[0]), 8'h1);
        chk("lit_rst_change", 0, 8'(rc[0]), 8'h1);

        // Short SE0 glitch is tolerated, full run detaches
        clr = 2'b01;
        step();
        clr = '0;
        line(0, 0);
        repeat (3) step();
        line(0, 1);
        step();
        chk("lit_glitch_enabled", 0, 8'(en[0]), 8'h1);
        line(0, 0);
        repeat (3) step();
        chk("lit_detach_early", 0, 8'(conn[0]), 8'h1);
        step();
        chk("lit_detach_conn", 0, 8'(conn[0]), 8'h0);
        chk("lit_detach_en", 0, 8'(en[0]), 8'h0);
        chk("lit_detach_cc", 0, 8'(cc[0]), 8'h1);

        // Clear coincident with a connect event keeps the bit
        clr = 2'b01;
        step();
        clr = '0;
        chk("lit_clear_alone", 0, 8'(cc[0]), 8'h0);
        line(0, 1);
        repeat (7) step();
        clr = 2'b01;
        step();
        clr = '0;
        chk("lit_setwins_conn", 0, 8'(conn[0]), 8'h1);
        chk("lit_setwins_cc", 0, 8'(cc[0]), 8'h1);

        // Bounce scenarios
        line(0, 0);
        repeat (4) step();
        chk("lit_bounce_detach", 0, 8'(conn[0]), 8'h0);
        line(0, 1);
        repeat (5) step();
        line(0, 0);
        step();
        line(0, 1);
        repeat (7) step();
        chk("lit_bounce_se0_early", 0, 8'(conn[0]), 8'h0);
        step();
        chk("lit_bounce_se0_conn", 0, 8'(conn[0]), 8'h1);
        line(0, 0);
        repeat (4) step();
        line(0, 1);
        repeat (5) step();
        line(0, 2);
        repeat (7) step();
        chk("lit_bounce_jk_early", 0, 8'(conn[0]), 8'h0);
        step();
        chk("lit_bounce_jk_conn", 0, 8'(conn[0]), 8'h1);
        chk("lit_bounce_jk_ls", 0, 8'(ls[0]), 8'h1);

        // Hub reset in the middle of a port reset
        rreq[1] = 1'b1;
        step();
        rreq[1] = 1'b0;
        repeat (4) step();
        chk("lit_midop_se0", 1, 8'(se0[1]), 8'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("lit_midop_conn", -1, 8'(conn), 8'h0);
        chk("lit_midop_en", -1, 8'(en), 8'h0);
        chk("lit_midop_se0_clr", -1, 8'(se0), 8'h0);
        chk("lit_midop_chg", -1, 8'({cc, rc}), 8'h0);
        chk("lit_midop_hub", -1, 8'(hub), 8'h0);

        // Randomized traffic
        for (int p = 0; p < N; p++) hold[p] = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            for (int p = 0; p < N; p++) begin
                if (hold[p] == 0) begin
                    int r;
                    r = int'($urandom_range(0, 99));
                    if (r < 40) line(p, 1);
                    else if (r < 70) line(p, 2);
                    else if (r < 95) line(p, 0);
                    else line(p, 3);
                    hold[p] = int'($urandom_range(1, 14));
                end
                hold[p]--;
                rreq[p] = ($urandom_range(0, 29) == 0);
                dreq[p] = ($urandom_range(0, 29) == 0);
                clr[p]  = ($urandom_range(0, 19) == 0);
            end
            reset = ($urandom_range(0, 1499) == 0);
            step();
        end

        rreq  = '0;
        dreq  = '0;
        clr   = '0;
        reset = 1'b0;
        step();
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
